// File: rtl/control_unit_if.sv
// Control-unit bundle: instruction-register fields and ALU flag in,
// stage enables and datapath control out.
interface control_unit_if;
    logic [1:0] InstructionType;
    logic [4:0] FunctionCode;
    logic       StopBit;
    logic       flag_zero;
    logic [2:0] sig_alu_op;
    logic [1:0] sig_pc_src;
    logic       sig_rb_src;
    logic [1:0] sig_alu_src;
    logic       sig_rf_enable_write;
    logic       sig_enable_data_memory_write;
    logic       sig_enable_data_memory_read;
    logic       sig_write_back_data_select;
    logic       en_instruction_fetch;
    logic       en_instruction_decode;
    logic       en_execute;

    modport master (
        input  InstructionType, FunctionCode, StopBit, flag_zero,
        output sig_alu_op, sig_pc_src, sig_rb_src, sig_alu_src,
        output sig_rf_enable_write, sig_enable_data_memory_write,
        output sig_enable_data_memory_read, sig_write_back_data_select,
        output en_instruction_fetch, en_instruction_decode, en_execute
    );

    modport slave (
        output InstructionType, FunctionCode, StopBit, flag_zero,
        input  sig_alu_op, sig_pc_src, sig_rb_src, sig_alu_src,
        input  sig_rf_enable_write, sig_enable_data_memory_write,
        input  sig_enable_data_memory_read, sig_write_back_data_select,
        input  en_instruction_fetch, en_instruction_decode, en_execute
    );
endinterface

// File: rtl/control_unit.sv
// Multicycle IF/ID/EX/MEM/WB control FSM for the 16-bit RISC core.
// Define CONTROL_UNIT_SHIFT_EN to decode S-type shifts (else they are NOPs).
module control_unit (
    input  logic          clock,
    input  logic          reset_n,
    control_unit_if.master bus
);
    typedef enum logic [2:0] {
        ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB
    } state_t;

    typedef enum logic [2:0] {
        K_NOP, K_ALU, K_LW, K_SW, K_BEQ, K_JMP
    } kind_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SLL = 3'd3;
    localparam logic [2:0] OP_SLR = 3'd4;

    state_t     state;
    state_t     state_nxt;
    kind_t      kind;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
    logic       rb_src;
    logic       wb_sel;
    logic       is_last;

    // Decode the held instruction into a sequence class and its mux values.
    always_comb begin
        kind    = K_NOP;
        alu_op  = OP_AND;
        alu_src = 2'd0;
        rb_src  = 1'b0;
        wb_sel  = 1'b0;
        case (bus.InstructionType)
            2'b00: begin
                case (bus.FunctionCode)
                    5'd0: begin kind = K_ALU; alu_op = OP_AND; end
                    5'd1: begin kind = K_ALU; alu_op = OP_ADD; end
                    5'd2: begin kind = K_ALU; alu_op = OP_SUB; end
                    5'd3: begin kind = K_ALU; alu_op = OP_SUB; end
                    default: ;
                endcase
            end
            2'b01: begin
                case (bus.FunctionCode)
                    5'd0: begin
                        kind = K_ALU; alu_op = OP_AND; alu_src = 2'd1;
                    end
                    5'd1: begin
                        kind = K_ALU; alu_op = OP_ADD; alu_src = 2'd1;
                    end
                    5'd2: begin
                        kind = K_LW; alu_op = OP_ADD; alu_src = 2'd1;
                        wb_sel = 1'b1;
                    end
                    5'd3: begin
                        kind = K_SW; alu_op = OP_ADD; alu_src = 2'd1;
                        rb_src = 1'b1;
                    end
                    5'd4: begin
                        kind = K_BEQ; alu_op = OP_SUB; rb_src = 1'b1;
                    end
                    default: ;
                endcase
            end
            2'b10: begin
                case (bus.FunctionCode)
                    5'd0, 5'd1: kind = K_JMP;
                    default: ;
                endcase
            end
            default: begin
`ifdef CONTROL_UNIT_SHIFT_EN
                case (bus.FunctionCode)
                    5'd0, 5'd2: begin
                        kind = K_ALU; alu_op = OP_SLL; alu_src = 2'd2;
                    end
                    5'd1, 5'd3: begin
                        kind = K_ALU; alu_op = OP_SLR; alu_src = 2'd2;
                    end
                    default: ;
                endcase
`endif
            end
        endcase
    end

    // Next stage: skip stages the instruction class does not use.
    always_comb begin
        state_nxt = ST_IF;
        case (state)
            ST_IF: state_nxt = ST_ID;
            ST_ID: begin
                if (kind == K_JMP || kind == K_NOP) state_nxt = ST_IF;
                else                                state_nxt = ST_EX;
            end
            ST_EX: begin
                if (kind == K_LW || kind == K_SW) state_nxt = ST_MEM;
                else if (kind == K_BEQ)           state_nxt = ST_IF;
                else                              state_nxt = ST_WB;
            end
            ST_MEM: begin
                if (kind == K_LW) state_nxt = ST_WB;
                else              state_nxt = ST_IF;
            end
            default: state_nxt = ST_IF;
        endcase
    end

    assign is_last = (state != ST_IF) && (state_nxt == ST_IF);

    // Stage register; reset abandons any instruction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IF;
        else          state <= state_nxt;
    end

    // Stage strobes and held mux selects, all forced low during reset.
    always_comb begin
        bus.sig_alu_op                   = 3'd0;
        bus.sig_pc_src                   = 2'd0;
        bus.sig_rb_src                   = 1'b0;
        bus.sig_alu_src                  = 2'd0;
        bus.sig_rf_enable_write          = 1'b0;
        bus.sig_enable_data_memory_write = 1'b0;
        bus.sig_enable_data_memory_read  = 1'b0;
        bus.sig_write_back_data_select   = 1'b0;
        bus.en_instruction_fetch         = 1'b0;
        bus.en_instruction_decode        = 1'b0;
        bus.en_execute                   = 1'b0;
        if (reset_n) begin
            if (state != ST_IF) begin
                bus.sig_alu_op                 = alu_op;
                bus.sig_alu_src                = alu_src;
                bus.sig_rb_src                 = rb_src;
                bus.sig_write_back_data_select = wb_sel;
            end
            case (state)
                ST_IF: bus.en_instruction_fetch = 1'b1;
                ST_ID: begin
                    bus.en_instruction_decode = 1'b1;
                    if (kind == K_JMP) bus.sig_pc_src = 2'd1;
                end
                ST_EX: begin
                    bus.en_execute = 1'b1;
                    if (kind == K_BEQ && bus.flag_zero)
                        bus.sig_pc_src = 2'd2;
                end
                ST_MEM: begin
                    bus.sig_enable_data_memory_read  = (kind == K_LW);
                    bus.sig_enable_data_memory_write = (kind == K_SW);
                end
                default: bus.sig_rf_enable_write = 1'b1;
            endcase
            if (is_last && bus.StopBit && kind != K_NOP &&
                bus.sig_pc_src == 2'd0)
                bus.sig_pc_src = 2'd3;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed sequences plus random instruction
// streams checked cycle by cycle against a stage-list reference model.
module tb_control_unit;
    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_bad;
    bit   shift_en;

    logic [14:0] exp_q[$];

    control_unit_if bus ();

    control_unit dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    // ClockGenerator: 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [14:0] observed();
        return {bus.sig_alu_op, bus.sig_pc_src, bus.sig_rb_src,
                bus.sig_alu_src, bus.sig_rf_enable_write,
                bus.sig_enable_data_memory_write,
                bus.sig_enable_data_memory_read,
                bus.sig_write_back_data_select,
                bus.en_instruction_fetch, bus.en_instruction_decode,
                bus.en_execute};
    endfunction

    task automatic check(input string tag, input logic [14:0] e);
        logic [14:0] o;
        o = observed();
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Reference: stage list from the instruction's class, outputs per stage.
    task automatic build(input logic [1:0] t, input logic [4:0] f,
                         input logic s, input logic z);
        int k;
        int ao, as_, rb, ws, pc;
        int stg[$];
        k = 0; ao = 0; as_ = 0; rb = 0; ws = 0;
        case (t)
            2'd0: if (f < 4) begin k = 1; ao = (f == 3) ? 2 : int'(f); end
            2'd1: case (f)
                5'd0: begin k = 1; ao = 0; as_ = 1; end
                5'd1: begin k = 1; ao = 1; as_ = 1; end
                5'd2: begin k = 2; ao = 1; as_ = 1; ws = 1; end
                5'd3: begin k = 3; ao = 1; as_ = 1; rb = 1; end
                5'd4: begin k = 4; ao = 2; rb = 1; end
                default: k = 0;
            endcase
            2'd2: if (f < 2) k = 5;
            default: if (shift_en && f < 4) begin
                k = 1; ao = (f % 2 == 0) ? 3 : 4; as_ = 2;
            end
        endcase
        stg = {0, 1};
        if (k >= 1 && k <= 4) stg.push_back(2);
        if (k == 2 || k == 3) stg.push_back(3);
        if (k == 1 || k == 2) stg.push_back(4);
        exp_q.delete();
        foreach (stg[i]) begin
            logic [14:0] v;
            bit fe, mr, mw, rfw;
            fe = (stg[i] == 0);
            pc = 0;
            if (stg[i] == 1 && k == 5) pc = 1;
            if (stg[i] == 2 && k == 4 && z) pc = 2;
            if (i == stg.size() - 1 && s && k != 0 && pc == 0) pc = 3;
            mr = (stg[i] == 3 && k == 2);
            mw = (stg[i] == 3 && k == 3);
            rfw = (stg[i] == 4);
            v = {fe ? 3'd0 : 3'(ao), 2'(pc), fe ? 1'b0 : 1'(rb),
                 fe ? 2'd0 : 2'(as_), rfw, mw, mr,
                 fe ? 1'b0 : 1'(ws), fe, stg[i] == 1, stg[i] == 2};
            exp_q.push_back(v);
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic [4:0] f,
                         input logic s, input logic z);
        bus.InstructionType = t;
        bus.FunctionCode    = f;
        bus.StopBit         = s;
        bus.flag_zero       = z;
        build(t, f, s, z);
    endtask

    // Entered #1 after the edge that starts IF; leaves in the next IF.
    task automatic run(input string tag, input logic [1:0] t,
                       input logic [4:0] f, input logic s,
                       input logic z);
        drive(t, f, s, z);
        foreach (exp_q[i]) begin
            @(negedge clock);
            check($sformatf("%s c%0d", tag, i + 1), exp_q[i]);
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
`ifdef CONTROL_UNIT_SHIFT_EN
        shift_en = 1'b1;
`else
        shift_en = 1'b0;
`endif
        reset_n = 1'b0;
        bus.InstructionType = 2'd0;
        bus.FunctionCode    = 5'd0;
        bus.StopBit         = 1'b0;
        bus.flag_zero       = 1'b0;
        #12;
        check("reset", 15'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        run("and",    2'd0, 5'd0, 1'b0, 1'b0);
        run("j",      2'd2, 5'd0, 1'b0, 1'b0);
        run("beq_nt", 2'd1, 5'd4, 1'b0, 1'b0);
        run("beq_t",  2'd1, 5'd4, 1'b0, 1'b1);
        run("lw",     2'd1, 5'd2, 1'b0, 1'b0);
        run("sw",     2'd1, 5'd3, 1'b0, 1'b0);
        run("addi_s", 2'd1, 5'd1, 1'b1, 1'b0);
        run("jal_s",  2'd2, 5'd1, 1'b1, 1'b0);
        run("beqt_s", 2'd1, 5'd4, 1'b1, 1'b1);
        run("sw_s",   2'd1, 5'd3, 1'b1, 1'b0);
        run("nop_r",  2'd0, 5'd9, 1'b0, 1'b0);
        run("sll",    2'd3, 5'd0, 1'b0, 1'b0);
        run("slrv",   2'd3, 5'd3, 1'b0, 1'b0);

        drive(2'd1, 5'd1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check($sformatf("addi_rst c%0d", i + 1), exp_q[i]);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check("addi_rst c3", exp_q[2]);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst", 15'd0);
        @(posedge clock);
        #1;
        check("rst_hold", 15'd0);
        reset_n = 1'b1;
        run("after_rst", 2'd0, 5'd1, 1'b0, 1'b0);

        for (int n = 0; n < 120; n++) begin
            logic [1:0] t;
            logic [4:0] f;
            logic       s;
            t = 2'($urandom_range(0, 3));
            f = 5'($urandom_range(0, 6));
            s = 1'($urandom_range(0, 1));
            build(t, f, 1'b0, 1'b0);
            if (exp_q.size() == 2 && exp_q[1][13:12] == 2'd0) s = 1'b0;
            run($sformatf("rnd%0d", n), t, f, s,
                1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
